c_result_collector: RTL
=======================

Name: c_result_collector

Overview:
- Sits directly downstream of the matrix compute block's C result stream (m_axis_c).
- Captures each 4-beat C burst (2x2 result: C00, C01, C10, C11) into a ping-pong pair of result banks.
- Exposes the completed banks to the control/readback side through a word-addressed read port with explicit release.
- Checks tlast framing and flags protocol violations in sticky error bits.

Parameters:
- DATA_W, 32, width of each C element and of rd_data
- BEATS, 4, beats per C frame (2x2 result; fixed, not re-parameterised elsewhere)
- CNT_W, 16, width of the committed-frame counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_c_tdata  in  DATA_W  C element
- s_axis_c_tvalid  in  1  beat valid
- s_axis_c_tready  out  1  beat accept
- s_axis_c_tlast  in  1  last beat of frame
- rd_addr  in  2  word index in current read bank (0=C00, 1=C01, 2=C10, 3=C11)
- rd_data  out  DATA_W  registered read data
- res_valid  out  1  at least one completed bank awaiting read
- res_release  in  1  pulse: frees current read bank
- frame_cnt  out  CNT_W  committed frames since reset
- err_early_last  out  1  sticky: tlast before beat 3
- err_missing_last  out  1  sticky: beat 3 without tlast
- clr_err  in  1  clears both sticky error bits

Behaviour:
- Reset (async, rst_n low):
  - s_axis_c_tready=0 while in reset, then 1 from the first cycle after deassertion.
  - rd_data=0, res_valid=0, frame_cnt=0, both error bits=0.
  - wr_bank=0, rd_bank=0, full_cnt=0, wr_idx=0, state=COLLECT.
  - Bank storage is not reset. Any partial frame in flight is lost.
- Handshake:
  - A beat is accepted when s_axis_c_tvalid && s_axis_c_tready.
  - s_axis_c_tready = (full_cnt != 2), driven from registered state only; there is no combinational path from tvalid or res_release.
- State COLLECT, on each accepted beat:
  - Write tdata into bank[wr_bank][wr_idx].
  - wr_idx==3 && tlast: commit the bank. full_cnt+1, wr_bank toggles, wr_idx=0, frame_cnt+1 (wraps at 2^CNT_W).
  - wr_idx<3 && tlast: set err_early_last, discard the frame (wr_idx=0, no commit), stay in COLLECT.
  - wr_idx==3 && !tlast: set err_missing_last, discard the frame, wr_idx=0, go to DISCARD.
  - Otherwise: wr_idx+1.
- State DISCARD:
  - Accepted beats are dropped (tready follows the same rule as COLLECT).
  - An accepted beat with tlast returns the block to COLLECT with wr_idx=0.
- Read side:
  - res_valid = (full_cnt != 0).
  - rd_data <= bank[rd_bank][rd_addr] every cycle, i.e. 1-cycle latency. The value is undefined-but-stable when res_valid=0.
  - res_release with res_valid=1: rd_bank toggles, full_cnt-1.
  - res_release with res_valid=0: ignored.
- Simultaneous events:
  - Commit and release in the same cycle: full_cnt unchanged, both pointers toggle.
  - full_cnt==2 with release in the same cycle: tready stays 0 this cycle and rises next cycle.
  - Error set and clr_err in the same cycle: set wins.
- Ordering: banks are read in commit order (FIFO depth 2). Writes never target a bank with full_cnt accounting it as unread.

Test Plan:
- Single frame: 4 beats 0x11, 0x22, 0x33, 0x44 with tlast on the 4th. Required: res_valid=1 the cycle after the last handshake, frame_cnt=1; rd_addr 0..3 returns 0x11..0x44 one cycle later each; release gives res_valid=0.
- Backpressure: 3 frames sent back-to-back, no release. Required: tready=0 after the 2nd commit and the 3rd frame stalls with 0 beats accepted; one release gives tready=1 next cycle; the 3rd frame then lands and reads return the 2nd frame's data first.
- Early tlast: tlast on beat 2 of a frame (values 5, 6). Required: err_early_last=1, frame_cnt unchanged; the next clean frame 7, 8, 9, 10 commits and reads correctly.
- Missing tlast: 4 beats with no tlast, then 2 more beats with tlast on the 2nd. Required: err_missing_last=1, all 6 beats dropped, frame_cnt unchanged; the next clean frame commits. clr_err clears both error bits next cycle.
- Same-cycle commit and release: full_cnt==1, last beat of a new frame coincides with res_release. Required: res_valid stays 1, rd_data reflects the new bank, frame_cnt+1.
- Reset mid-frame: assert rst_n low after 2 beats. Required: all outputs return to reset values; a following full frame commits cleanly with frame_cnt=1.

Source files
------------

// File: rtl/c_result_collector_if.sv
// C result stream, bank read port and status/error signals of the result collector.
interface c_result_collector_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] s_axis_c_tdata;
  logic              s_axis_c_tvalid;
  logic              s_axis_c_tready;
  logic              s_axis_c_tlast;
  logic [1:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              res_valid;
  logic              res_release;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_early_last;
  logic              err_missing_last;
  logic              clr_err;

  modport master (
    output s_axis_c_tdata, s_axis_c_tvalid, s_axis_c_tlast, rd_addr, res_release, clr_err,
    input  s_axis_c_tready, rd_data, res_valid, frame_cnt, err_early_last, err_missing_last
  );

  modport slave (
    input  s_axis_c_tdata, s_axis_c_tvalid, s_axis_c_tlast, rd_addr, res_release, clr_err,
    output s_axis_c_tready, rd_data, res_valid, frame_cnt, err_early_last, err_missing_last
  );
endinterface

// File: rtl/c_result_collector.sv
// Captures 4-beat 2x2 C bursts into ping-pong banks; read data has 1-cycle latency.
// tready drops while both banks hold unread results and returns the cycle after a release.
module c_result_collector #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  c_result_collector_if.slave   bus
);
  localparam int IDX_W = $clog2(BEATS);

  typedef enum logic {COLLECT, DISCARD} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  wr_idx, wr_idx_nxt;
  logic              wr_bank, rd_bank;
  logic [1:0]        full_cnt, full_cnt_nxt;
  logic              tready_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              err_early_q, err_miss_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] bank_mem [2][BEATS];

  logic accept, rel_ok, last_idx;
  logic commit, early, missing, wr_en;

  assign accept   = bus.s_axis_c_tvalid && tready_q;
  assign rel_ok   = bus.res_release && (full_cnt != 2'd0);
  assign last_idx = (wr_idx == IDX_W'(BEATS - 1));

  always_comb begin
    state_nxt    = state;
    wr_idx_nxt   = wr_idx;
    commit       = 1'b0;
    early        = 1'b0;
    missing      = 1'b0;
    wr_en        = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.s_axis_c_tlast) begin
            wr_idx_nxt = '0;
            commit     = last_idx;
            early      = !last_idx;
          end else if (last_idx) begin
            wr_idx_nxt = '0;
            missing    = 1'b1;
            state_nxt  = DISCARD;
          end else begin
            wr_idx_nxt = wr_idx + IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        if (accept && bus.s_axis_c_tlast) begin
          state_nxt  = COLLECT;
          wr_idx_nxt = '0;
        end
      end
      default: state_nxt = COLLECT;
    endcase
    full_cnt_nxt = full_cnt + 2'(commit) - 2'(rel_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full_cnt    <= 2'd0;
      tready_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_early_q <= 1'b0;
      err_miss_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state       <= state_nxt;
      wr_idx      <= wr_idx_nxt;
      full_cnt    <= full_cnt_nxt;
      // Registered from next occupancy so tready never depends on tvalid or release combinationally
      tready_q    <= (full_cnt_nxt != 2'd2);
      rd_data_q   <= bank_mem[rd_bank][bus.rd_addr];
      if (commit) begin
        wr_bank     <= !wr_bank;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (rel_ok) rd_bank <= !rd_bank;
      if (early) err_early_q <= 1'b1;
      else if (bus.clr_err) err_early_q <= 1'b0;
      if (missing) err_miss_q <= 1'b1;
      else if (bus.clr_err) err_miss_q <= 1'b0;
    end
  end

  // Bank storage carries no reset
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[wr_bank][wr_idx] <= bus.s_axis_c_tdata;
  end

  assign bus.s_axis_c_tready  = tready_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.res_valid        = (full_cnt != 2'd0);
  assign bus.frame_cnt        = frame_cnt_q;
  assign bus.err_early_last   = err_early_q;
  assign bus.err_missing_last = err_miss_q;
endmodule
